// File: rtl/pwm_cfg_parser.sv
// pwm_cfg_parser: validates framed PWM config commands and broadcasts a one-cycle config pulse
module pwm_cfg_parser #(
  parameter int NUM_CHANNELS = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        pwm_config_vld,
  output logic [7:0]  pwm_config_channel,
  output logic        pwm_en,
  output logic [27:0] pwm_period,
  output logic [27:0] pwm_hlevel,
  output logic        frame_err,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {HUNT, CHAN, FLAGS, PERIOD, HLEVEL, CSUM, EMIT} state_t;
  state_t state;
  logic [7:0] chan_r, flags_r, csum_r;
  logic [31:0] period_r, hlevel_r;
  logic [1:0] idx;
  logic [TW-1:0] to_cnt;
  logic acc, in_frame, timeout, good;
  assign s_ready = state != EMIT;
  assign acc = s_valid && s_ready;
  assign in_frame = state inside {CHAN, FLAGS, PERIOD, HLEVEL, CSUM};
  assign timeout = in_frame && !acc && to_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign good = s_data == csum_r && 32'(chan_r) < NUM_CHANNELS && flags_r[7:1] == 7'd0
    && period_r[31:28] == 4'd0 && hlevel_r[31:28] == 4'd0;
  // Frame FSM: byte capture, running XOR, inter-byte timeout and the registered result pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      chan_r <= '0;
      flags_r <= '0;
      csum_r <= '0;
      period_r <= '0;
      hlevel_r <= '0;
      idx <= '0;
      to_cnt <= '0;
      pwm_config_vld <= 1'b0;
      frame_err <= 1'b0;
      pwm_config_channel <= '0;
      pwm_en <= 1'b0;
      pwm_period <= '0;
      pwm_hlevel <= '0;
      ok_cnt <= '0;
      err_cnt <= '0;
    end else begin
      pwm_config_vld <= 1'b0;
      frame_err <= 1'b0;
      to_cnt <= (acc || !in_frame || timeout) ? '0 : to_cnt + TW'(1);
      if (timeout) begin
        state <= HUNT;
        frame_err <= 1'b1;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end else if (acc) begin
        case (state)
          HUNT: begin
            csum_r <= '0;
            idx <= '0;
            if (s_data == SYNC_BYTE) state <= CHAN;
          end
          CHAN: begin
            chan_r <= s_data;
            csum_r <= csum_r ^ s_data;
            state <= FLAGS;
          end
          FLAGS: begin
            flags_r <= s_data;
            csum_r <= csum_r ^ s_data;
            state <= PERIOD;
          end
          PERIOD: begin
            period_r <= {period_r[23:0], s_data};
            csum_r <= csum_r ^ s_data;
            idx <= idx + 2'd1;
            if (idx == 2'd3) state <= HLEVEL;
          end
          HLEVEL: begin
            hlevel_r <= {hlevel_r[23:0], s_data};
            csum_r <= csum_r ^ s_data;
            idx <= idx + 2'd1;
            if (idx == 2'd3) state <= CSUM;
          end
          CSUM: begin
            state <= EMIT;
            if (good) begin
              pwm_config_vld <= 1'b1;
              pwm_config_channel <= chan_r;
              pwm_en <= flags_r[0];
              pwm_period <= period_r[27:0];
              pwm_hlevel <= hlevel_r[27:0];
              if (ok_cnt != 16'hFFFF) ok_cnt <= ok_cnt + 16'd1;
            end else begin
              frame_err <= 1'b1;
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end else if (state == EMIT) begin
        state <= HUNT;
      end
    end
  end
endmodule

// File: tb/tb_pwm_cfg_parser.sv
// tb_pwm_cfg_parser: scoreboard bench for the PWM config frame parser
module tb_pwm_cfg_parser;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] s_data;
  logic s_valid;
  logic s_ready;
  logic pwm_config_vld;
  logic [7:0] pwm_config_channel;
  logic pwm_en;
  logic [27:0] pwm_period;
  logic [27:0] pwm_hlevel;
  logic frame_err;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;

  typedef struct packed {
    logic err;
    logic rdy;
    logic [7:0] ch;
    logic en;
    logic [27:0] per;
    logic [27:0] hl;
    logic [15:0] okc;
    logic [15:0] errc;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int fails = 0;
  logic [7:0] m_ch = '0;
  logic m_en = 1'b0;
  logic [27:0] m_per = '0;
  logic [27:0] m_hl = '0;
  logic [15:0] m_ok = '0;
  logic [15:0] m_err = '0;

  pwm_cfg_parser #(.NUM_CHANNELS(8), .TIMEOUT_CYCLES(50), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk),
    .rst(rst),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .pwm_config_vld(pwm_config_vld),
    .pwm_config_channel(pwm_config_channel),
    .pwm_en(pwm_en),
    .pwm_period(pwm_period),
    .pwm_hlevel(pwm_hlevel),
    .frame_err(frame_err),
    .ok_cnt(ok_cnt),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push_event(input logic err, input logic rdy);
    exp_t e;
    e.err = err;
    e.rdy = rdy;
    e.ch = m_ch;
    e.en = m_en;
    e.per = m_per;
    e.hl = m_hl;
    e.okc = m_ok;
    e.errc = m_err;
    exp_q.push_back(e);
  endtask

  task automatic expect_reject(input logic rdy);
    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
    push_event(1'b1, rdy);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_data = b;
    s_valid = 1'b1;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      fails++;
      $display("FAIL s_ready_stuck: got 0 want 1");
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] ch, input logic [7:0] fl, input logic [31:0] per,
                            input logic [31:0] hl, input logic [7:0] cx, input logic good,
                            input int gmax, input int nbytes);
    logic [7:0] b [12];
    logic [7:0] cs;
    b = '{8'hA5, ch, fl, per[31:24], per[23:16], per[15:8], per[7:0],
          hl[31:24], hl[23:16], hl[15:8], hl[7:0], 8'h00};
    cs = 8'h00;
    for (int i = 1; i < 11; i++) cs = cs ^ b[i];
    b[11] = cs ^ cx;
    if (nbytes == 12) begin
      if (good) begin
        m_ch = ch;
        m_en = fl[0];
        m_per = per[27:0];
        m_hl = hl[27:0];
        if (m_ok != 16'hFFFF) m_ok = m_ok + 16'd1;
        push_event(1'b0, 1'b0);
      end else begin
        expect_reject(1'b0);
      end
    end
    for (int i = 0; i < nbytes; i++) send_byte(b[i], gmax > 0 ? int'($urandom_range(0, gmax)) : 0);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (pwm_config_vld || frame_err)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got vld=%0b err=%0b want no event", pwm_config_vld, frame_err);
      end else begin
        e = exp_q.pop_front();
        if (frame_err !== e.err || pwm_config_vld !== !e.err || s_ready !== e.rdy ||
            pwm_config_channel !== e.ch || pwm_en !== e.en || pwm_period !== e.per ||
            pwm_hlevel !== e.hl || ok_cnt !== e.okc || err_cnt !== e.errc) begin
          fails++;
          $display("FAIL event: got err=%0b vld=%0b rdy=%0b ch=%0d en=%0b per=%0d hl=%0d ok=%0h errc=%0h want err=%0b vld=%0b rdy=%0b ch=%0d en=%0b per=%0d hl=%0d ok=%0h errc=%0h",
                   frame_err, pwm_config_vld, s_ready, pwm_config_channel, pwm_en, pwm_period, pwm_hlevel, ok_cnt, err_cnt,
                   e.err, !e.err, e.rdy, e.ch, e.en, e.per, e.hl, e.okc, e.errc);
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(s_ready), 32'd1);
    check("reset_pulses", {30'd0, pwm_config_vld, frame_err}, 32'd0);
    check("reset_fields", 32'(pwm_config_channel) | 32'(pwm_en) | 32'(pwm_period) | 32'(pwm_hlevel), 32'd0);
    check("reset_counts", {ok_cnt, err_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send_frame(8'd2, 8'h01, 32'd1000, 32'd500, 8'h00, 1'b1, 0, 12);
    check("ready_after_emit", 32'(s_ready), 32'd1);
    send_frame(8'd2, 8'h01, 32'd1000, 32'd500, 8'h01, 1'b0, 0, 12);
    send_frame(8'd8, 8'h01, 32'd1000, 32'd500, 8'h00, 1'b0, 0, 12);
    send_frame(8'd1, 8'h01, 32'h1000_03E8, 32'd500, 8'h00, 1'b0, 0, 12);
    send_frame(8'd1, 8'h03, 32'd1000, 32'd500, 8'h00, 1'b0, 0, 12);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] nb;
      nb = 8'($urandom_range(0, 255));
      send_byte(nb == 8'hA5 ? 8'h5A : nb, 0);
    end
    check("noise_err_cnt", 32'(err_cnt), 32'd4);
    send_frame(8'd0, 8'h00, 32'd0, 32'd0, 8'h00, 1'b1, 10, 12);
    expect_reject(1'b1);
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    n = 0;
    while (!frame_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, 50);
    repeat (10) @(negedge clk);
    send_frame(8'd5, 8'h01, 32'h00A5_00A5, 32'h0FFF_FFFF, 8'h00, 1'b1, 0, 12);
    send_frame(8'd2, 8'h01, 32'd1000, 32'd500, 8'h00, 1'b0, 0, 6);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ch = '0; m_en = 1'b0; m_per = '0; m_hl = '0; m_ok = '0; m_err = '0;
    check("midreset_counts", {ok_cnt, err_cnt}, 32'd0);
    send_frame(8'd7, 8'h01, 32'h0FFF_FFFF, 32'd0, 8'h00, 1'b1, 0, 12);
    check("midreset_ok_cnt", 32'(ok_cnt), 32'd1);
    dut.err_cnt <= 16'hFFFD;
    @(negedge clk);
    m_err = 16'hFFFD;
    for (int i = 0; i < 3; i++) send_frame(8'd3, 8'h00, 32'd10, 32'h1000_0000, 8'h00, 1'b0, 0, 12);
    check("sat_err_cnt", 32'(err_cnt), 32'h0000_FFFF);
    check("sat_ok_cnt", 32'(ok_cnt), 32'd1);
    check("final_fields", {pwm_config_channel, 3'd0, pwm_en, pwm_hlevel[19:0]}, {8'd7, 3'd0, 1'b1, 20'd0});
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
